// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// refresh FSM state encoding and default timing constants.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam int DEF_REF_INTERVAL = 750;
  localparam int DEF_T_RP         = 2;
  localparam int DEF_T_RFC        = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_TRP_WAIT,
    ST_AREF,
    ST_TRFC_WAIT,
    ST_END
  } aref_state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer gated by first init_end, plus saturating owed-refresh counter.
// Tick and issue both take effect on the same edge; a tick lost at saturation sets a sticky flag.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = DEF_REF_INTERVAL,
  parameter int MAX_PEND     = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_tick_en,
  input  logic                          i_issue,
  output logic [$clog2(MAX_PEND+1)-1:0] o_pending,
  output logic                          o_overflow
);

  localparam int TW = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
  localparam int PW = $clog2(MAX_PEND+1);

  logic          r_started;
  logic [TW-1:0] r_timer;
  logic [PW-1:0] r_pending;
  logic          r_overflow;
  logic          w_tick;
  logic          w_full;

  assign w_tick = r_started && (r_timer == TW'(REF_INTERVAL-1));
  assign w_full = (r_pending == PW'(MAX_PEND));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_started  <= 1'b0;
      r_timer    <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Sticky: a later drop of init_end does not stop refresh accounting.
      if (i_tick_en) r_started <= 1'b1;
      if (r_started) r_timer <= w_tick ? '0 : r_timer + 1'b1;
      if (w_tick && !i_issue) begin
        if (w_full) r_overflow <= 1'b1;
        else        r_pending  <= r_pending + 1'b1;
      end else if (i_issue && !w_tick) begin
        r_pending <= r_pending - 1'b1;
      end
    end
  end

  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/sdram_a_ref_multi.sv
// Auto-refresh generator: on grant issues PRECHARGE-ALL then up to MAX_BURST AUTO-REFRESHes.
// PRE at c0, AREF k at c0+T_RP+k*T_RFC, a_ref_end at c0+T_RP+n*T_RFC; grant only sampled in IDLE.
module sdram_a_ref_multi
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = DEF_REF_INTERVAL,
  parameter int T_RP         = DEF_T_RP,
  parameter int T_RFC        = DEF_T_RFC,
  parameter int MAX_PEND     = 8,
  parameter int MAX_BURST    = 4,
  parameter int URGENT_TH    = 6,
  parameter int ADDR_W       = 13,
  parameter int BA_W         = 2
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          init_end,
  input  logic                          a_ref_en,
  output logic                          a_ref_req,
  output logic                          a_ref_urgent,
  output logic [3:0]                    a_ref_cmd,
  output logic [BA_W-1:0]               a_ref_ba,
  output logic [ADDR_W-1:0]             a_ref_addr,
  output logic                          a_ref_end,
  output logic [$clog2(MAX_PEND+1)-1:0] ref_pending,
  output logic                          ref_overflow
);

  localparam int PW   = $clog2(MAX_PEND+1);
  localparam int BW   = $clog2(MAX_BURST+1);
  localparam int WMAX = (T_RFC > T_RP) ? T_RFC : T_RP;
  localparam int CW   = (WMAX > 2) ? $clog2(WMAX) : 1;

  aref_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_wait, w_wait_nxt;
  logic [BW-1:0] r_burst_n, w_burst_nxt;
  logic [BW-1:0] r_issued, w_issued_nxt;
  logic [PW-1:0] w_pending;
  logic [3:0]    w_cmd;
  logic          w_issue;
  logic          w_end;

  sdram_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .MAX_PEND     (MAX_PEND)
  ) u_timer (
    .i_clk      (sys_clk),
    .i_rst_n    (sys_rst_n),
    .i_tick_en  (init_end),
    .i_issue    (w_issue),
    .o_pending  (w_pending),
    .o_overflow (ref_overflow)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_burst_n <= '0;
      r_issued  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_burst_n <= w_burst_nxt;
      r_issued  <= w_issued_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait;
    w_burst_nxt  = r_burst_n;
    w_issued_nxt = r_issued;
    w_cmd        = CMD_NOP;
    w_issue      = 1'b0;
    w_end        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (a_ref_en && (w_pending != '0)) begin
          w_burst_nxt  = (w_pending > PW'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(w_pending);
          w_issued_nxt = '0;
          w_state_nxt  = ST_PRE;
        end
      end
      ST_PRE: begin
        w_cmd       = CMD_PRE;
        w_wait_nxt  = '0;
        w_state_nxt = (T_RP > 1) ? ST_TRP_WAIT : ST_AREF;
      end
      ST_TRP_WAIT: begin
        if (r_wait == CW'(T_RP-2)) w_state_nxt = ST_AREF;
        else                       w_wait_nxt  = r_wait + 1'b1;
      end
      ST_AREF: begin
        w_cmd        = CMD_AREF;
        w_issue      = 1'b1;
        w_issued_nxt = r_issued + 1'b1;
        w_wait_nxt   = '0;
        if (T_RFC > 1) w_state_nxt = ST_TRFC_WAIT;
        else           w_state_nxt = (w_issued_nxt < r_burst_n) ? ST_AREF : ST_END;
      end
      ST_TRFC_WAIT: begin
        if (r_wait == CW'(T_RFC-2)) w_state_nxt = (r_issued < r_burst_n) ? ST_AREF : ST_END;
        else                        w_wait_nxt  = r_wait + 1'b1;
      end
      ST_END: begin
        w_end       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // All-ones address keeps A10 high for PRECHARGE-ALL.
  assign a_ref_cmd    = w_cmd;
  assign a_ref_ba     = '1;
  assign a_ref_addr   = '1;
  assign a_ref_end    = w_end;
  assign a_ref_req    = (r_state == ST_IDLE) && (w_pending != '0);
  assign a_ref_urgent = (w_pending >= PW'(URGENT_TH));
  assign ref_pending  = w_pending;

endmodule

// File: tb/tb_sdram_a_ref_multi.sv
// Scoreboard bench: stimulus predicts command events from the refresh rules, monitor pops and compares.
module tb_sdram_a_ref_multi;
  import sdram_pkg::*;

  localparam int RI   = 20;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int MAXP = 8;
  localparam int MAXB = 4;
  localparam int UTH  = 6;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_end  = 1'b0;
  logic        a_ref_en  = 1'b0;
  logic        a_ref_req, a_ref_urgent, a_ref_end, ref_overflow;
  logic [3:0]  a_ref_cmd;
  logic [1:0]  a_ref_ba;
  logic [12:0] a_ref_addr;
  logic [3:0]  ref_pending;

  sdram_a_ref_multi #(
    .REF_INTERVAL (RI), .T_RP (TRP), .T_RFC (TRFC), .MAX_PEND (MAXP),
    .MAX_BURST (MAXB), .URGENT_TH (UTH), .ADDR_W (13), .BA_W (2)
  ) dut (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .init_end (init_end), .a_ref_en (a_ref_en),
    .a_ref_req (a_ref_req), .a_ref_urgent (a_ref_urgent), .a_ref_cmd (a_ref_cmd),
    .a_ref_ba (a_ref_ba), .a_ref_addr (a_ref_addr), .a_ref_end (a_ref_end),
    .ref_pending (ref_pending), .ref_overflow (ref_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed { int cyc; logic [4:0] kind; } ev_t;  // kind = {end, cmd}
  ev_t exp_q[$];
  int  aref_q[$];

  int cyc = 0;
  int passed = 0;
  int total = 0;

  // Reference model: owed refreshes, sticky overflow, start flag, busy window of current grant.
  int m_pend = 0;
  bit m_ovf = 0;
  bit m_started = 0;
  int m_e0 = 0;
  int m_c0 = -1;
  int m_cend = -2;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
  endtask

  task automatic model_reset();
    m_pend = 0; m_ovf = 0; m_started = 0; m_e0 = 0; m_c0 = -1; m_cend = -2;
    exp_q.delete(); aref_q.delete();
  endtask

  task automatic step();
    bit tk, is;
    @(posedge sys_clk);
    cyc++;
    if (!sys_rst_n) begin
      model_reset();
    end else begin
      tk = m_started && (cyc > m_e0) && (((cyc - m_e0) % RI) == 0);
      is = 0;
      if (aref_q.size() > 0 && aref_q[0] == cyc - 1) begin
        is = 1;
        void'(aref_q.pop_front());
      end
      if (tk && !is) begin
        if (m_pend == MAXP) m_ovf = 1;
        else m_pend++;
      end else if (is && !tk) begin
        m_pend--;
      end
      if (!m_started && init_end) begin
        m_started = 1;
        m_e0 = cyc;
      end
    end
    #1;
    if (a_ref_en && cyc == m_cend + 1) a_ref_en = 1'b0;
  endtask

  // Waits for an idle, owed state, then grants and predicts the whole sequence.
  task automatic grant(input int delay, input bit align);
    int g, n, c0;
    g = 0;
    while (!(m_pend > 0 && cyc > m_cend + 1) && g < 2000) begin step(); g++; end
    if (g >= 2000) begin
      check("grant_wait_timeout", 0, 1);
      return;
    end
    repeat (delay) step();
    if (align)
      for (int i = 0; i < RI && ((cyc + 4 - m_e0) % RI) != 0; i++) step();
    n  = (m_pend > MAXB) ? MAXB : m_pend;
    c0 = cyc + 1;
    a_ref_en = 1'b1;
    m_c0 = c0;
    exp_q.push_back('{c0, {1'b0, CMD_PRE}});
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{c0 + TRP + k * TRFC, {1'b0, CMD_AREF}});
      aref_q.push_back(c0 + TRP + k * TRFC);
    end
    m_cend = c0 + TRP + n * TRFC;
    exp_q.push_back('{m_cend, {1'b1, CMD_NOP}});
  endtask

  task automatic wait_done();
    int g = 0;
    while (cyc <= m_cend + 1 && g < 200) begin step(); g++; end
  endtask

  task automatic wait_pend(input int target);
    int g = 0;
    while (m_pend < target && g < 400) begin step(); g++; end
    if (g >= 400) check("wait_pend_timeout", m_pend, target);
  endtask

  task automatic first_req(input string nm);
    int g = 0;
    while (a_ref_req !== 1'b1 && g < 3 * RI) begin step(); g++; end
    check(nm, cyc - m_e0, RI);
  endtask

  // Monitor: every cycle compares status outputs; on a command/end event pops the scoreboard.
  always @(negedge sys_clk) begin : mon
    bit   busy;
    ev_t  e;
    busy = (cyc >= m_c0) && (cyc <= m_cend);
    check("status{req,urg,pend,ovf}",
          {a_ref_req, a_ref_urgent, ref_pending, ref_overflow},
          {(!busy && m_pend != 0), (m_pend >= UTH), 4'(m_pend), m_ovf});
    if (a_ref_cmd == CMD_NOP) check("nop_ba_addr", {a_ref_ba, a_ref_addr}, 15'h7fff);
    if (a_ref_cmd != CMD_NOP || a_ref_end) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_event cyc=%0d got=%b expected=none", cyc, {a_ref_end, a_ref_cmd});
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_kind", {a_ref_end, a_ref_cmd}, e.kind);
        if (a_ref_cmd == CMD_PRE) check("pre_a10", a_ref_addr[10], 1'b1);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      total++;
      $display("FAIL missed_event expected_cyc=%0d got=none expected=%b", e.cyc, e.kind);
    end
  end

  initial begin
    repeat (3) step();
    check("rst_cmd", a_ref_cmd, CMD_NOP);
    check("rst_ba_addr", {a_ref_ba, a_ref_addr}, 15'h7fff);
    check("rst_flags", {a_ref_req, a_ref_urgent, a_ref_end, ref_overflow, ref_pending}, 0);
    sys_rst_n = 1'b1;
    repeat (5) step();
    check("no_req_before_init", a_ref_req, 1'b0);
    init_end = 1'b1;

    first_req("first_req_delay");
    grant(0, 0);
    wait_done();
    init_end = 1'b0;  // ignored once started

    wait_pend(3);
    grant(0, 0);
    wait_done();

    wait_pend(6);
    check("urgent_at_6", a_ref_urgent, 1'b1);
    grant(0, 1);
    wait_done();

    begin : ovf_phase
      int g = 0;
      while (!m_ovf && g < 400) begin step(); g++; end
      check("overflow_set", ref_overflow, 1'b1);
    end
    for (int r = 0; r < 4; r++) begin grant(0, 0); wait_done(); end
    check("overflow_sticky", ref_overflow, 1'b1);

    for (int r = 0; r < 8; r++) begin
      wait_pend($urandom_range(1, 7));
      grant($urandom_range(0, 25), 1'($urandom_range(0, 1)));
      wait_done();
    end

    grant(0, 0);
    while (cyc < m_c0 + TRP + 3) step();
    sys_rst_n = 1'b0;
    init_end  = 1'b0;
    a_ref_en  = 1'b0;
    model_reset();
    #1;
    check("midseq_rst_cmd", a_ref_cmd, CMD_NOP);
    check("midseq_rst_pend", {ref_pending, ref_overflow, a_ref_end, a_ref_req}, 0);
    repeat (2) step();
    sys_rst_n = 1'b1;
    repeat (10) step();
    init_end = 1'b1;
    first_req("post_reset_req_delay");
    grant(1, 0);
    wait_done();

    repeat (5) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
